// File: rtl/jt900h_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : jt900h_prefetch
//  Purpose  : JT900H instruction prefetch queue. Fetches 16-bit words into an
//             8-byte queue and presents the four head bytes to the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module jt900h_prefetch #(
  parameter logic [23:0] PC_RST = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [1:0]  fetched,
  input  logic        pc_we,
  input  logic [23:0] pc_din,
  output logic [31:0] op,
  output logic        op_ok,
  output logic [23:0] pc,
  output logic [23:0] bus_addr,
  output logic        bus_rd,
  input  logic [15:0] bus_din,
  input  logic        bus_ok
);

  logic [63:0] r_qbuf;
  logic [3:0]  r_cnt;
  logic [22:0] r_faddr;
  logic        r_skip;
  logic [23:0] r_pc;
  logic        r_rd;
  logic        r_op_ok;

  logic        w_take;
  logic [1:0]  w_fet;
  logic [3:0]  w_cnt_mid;
  logic [3:0]  w_app_n;
  logic [15:0] w_app_data;
  logic [63:0] w_shifted;
  logic [63:0] w_ins;
  logic [63:0] w_qbuf_next;
  logic [3:0]  w_cnt_next;

  assign w_take = r_rd & bus_ok;

  // An over-consuming controller is clamped to whatever is actually queued
  assign w_fet      = ({2'b00, fetched} > r_cnt) ? r_cnt[1:0] : fetched;
  assign w_cnt_mid  = r_cnt - {2'b00, w_fet};
  assign w_app_n    = w_take ? (r_skip ? 4'd1 : 4'd2) : 4'd0;
  assign w_app_data = !w_take ? 16'h0000 :
                      r_skip  ? {8'h00, bus_din[15:8]} : bus_din;

  // Bytes past the valid count stay zero, so a plain OR merges the new data
  assign w_shifted   = r_qbuf >> {w_fet, 3'b000};
  assign w_ins       = {48'h0, w_app_data} << {w_cnt_mid, 3'b000};
  assign w_qbuf_next = w_shifted | w_ins;
  assign w_cnt_next  = w_cnt_mid + w_app_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qbuf  <= 64'h0;
      r_cnt   <= 4'd0;
      r_faddr <= PC_RST[23:1];
      r_skip  <= PC_RST[0];
      r_pc    <= PC_RST;
      r_rd    <= 1'b0;
      r_op_ok <= 1'b0;
    end else if (cen) begin
      if (pc_we) begin
        r_qbuf  <= 64'h0;
        r_cnt   <= 4'd0;
        r_faddr <= pc_din[23:1];
        r_skip  <= pc_din[0];
        r_pc    <= pc_din;
        r_rd    <= 1'b0;
        r_op_ok <= 1'b0;
      end else begin
        r_qbuf  <= w_qbuf_next;
        r_cnt   <= w_cnt_next;
        r_pc    <= r_pc + {22'd0, w_fet};
        if (w_take) begin
          r_faddr <= r_faddr + 23'd1;
          r_skip  <= 1'b0;
        end
        // Requesting only while a full word is guaranteed to fit
        r_rd    <= (w_cnt_next <= 4'd6);
        r_op_ok <= (w_cnt_next >= 4'd4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cen && !pc_we) begin
      assert ({2'b00, fetched} <= r_cnt)
        else $error("jt900h_prefetch: fetched=%0d exceeds queued bytes=%0d", fetched, r_cnt);
    end
  end

  assign op       = r_qbuf[31:0];
  assign op_ok    = r_op_ok;
  assign pc       = r_pc;
  assign bus_addr = {r_faddr, 1'b0};
  assign bus_rd   = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_jt900h_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt900h_prefetch
//  Purpose  : Directed self-checking bench for jt900h_prefetch with a simple
//             wait-state memory model (byte value = address low byte).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt900h_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [1:0]  fetched;
  logic        pc_we;
  logic [23:0] pc_din;
  logic [31:0] op;
  logic        op_ok;
  logic [23:0] pc;
  logic [23:0] bus_addr;
  logic        bus_rd;
  logic [15:0] bus_din;
  logic        bus_ok;

  int checks   = 0;
  int failures = 0;
  int mem_wait = 0;
  int wcnt     = 0;
  bit toggle   = 1'b0;
  int n;

  jt900h_prefetch #(.PC_RST(24'h000000)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .fetched  (fetched),
    .pc_we    (pc_we),
    .pc_din   (pc_din),
    .op       (op),
    .op_ok    (op_ok),
    .pc       (pc),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_din  (bus_din),
    .bus_ok   (bus_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return {a[7:0] + 8'd1, a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, then the
  // memory model decides bus_ok/bus_din for the coming cycle.
  task automatic tick();
    logic ok_q, rd_q, cen_q;
    ok_q  = bus_ok;
    rd_q  = bus_rd;
    cen_q = cen;
    @(posedge clk);
    #1;
    if (ok_q && rd_q && cen_q) wcnt = 0;
    if (toggle) begin
      bus_ok  = ~bus_ok;
      bus_din = mem_word(bus_addr);
    end else if (!bus_rd) begin
      bus_ok = 1'b0;
      wcnt   = 0;
    end else if (wcnt >= mem_wait) begin
      bus_ok  = 1'b1;
      bus_din = mem_word(bus_addr);
    end else begin
      bus_ok = 1'b0;
      wcnt++;
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; fetched = 2'd0; pc_we = 1'b0; pc_din = 24'h0;
    bus_ok = 1'b0; bus_din = 16'h0;

    // Reset and straight fill
    tick(); tick();
    check("rst_bus_rd",   64'(bus_rd),   64'h0);
    check("rst_bus_addr", 64'(bus_addr), 64'h0);
    check("rst_op",       64'(op),       64'h0);
    check("rst_op_ok",    64'(op_ok),    64'h0);
    check("rst_pc",       64'(pc),       64'h0);
    rst = 1'b0;
    tick();
    check("fill_rd_rise", 64'(bus_rd),   64'h1);
    check("fill_addr0",   64'(bus_addr), 64'h0);
    tick();
    check("fill_addr2",   64'(bus_addr), 64'h2);
    check("fill_ok_early",64'(op_ok),    64'h0);
    tick();
    check("fill_op_ok",   64'(op_ok),    64'h1);
    check("fill_op",      64'(op),       64'h03020100);
    check("fill_pc",      64'(pc),       64'h0);
    tick();
    check("fill_rd_cnt6", 64'(bus_rd),   64'h1);
    tick();
    check("fill_rd_full", 64'(bus_rd),   64'h0);
    check("fill_addr8",   64'(bus_addr), 64'h8);

    // Consumption mix
    fetched = 2'd1; tick();
    check("cons1_pc",     64'(pc),       64'h1);
    check("cons1_op",     64'(op),       64'h04030201);
    check("cons1_rd",     64'(bus_rd),   64'h0);
    fetched = 2'd2; tick();
    check("cons2_pc",     64'(pc),       64'h3);
    check("cons2_head",   64'(op[7:0]),  64'h03);
    check("cons2_op",     64'(op),       64'h06050403);
    check("cons2_rd",     64'(bus_rd),   64'h1);
    check("cons2_addr",   64'(bus_addr), 64'h8);
    fetched = 2'd3; tick();
    check("cons3_pc",     64'(pc),       64'h6);
    check("cons3_op",     64'(op),       64'h09080706);
    check("cons3_op_ok",  64'(op_ok),    64'h1);
    check("cons3_addr",   64'(bus_addr), 64'hA);
    fetched = 2'd0; tick();
    check("cons4_addr",   64'(bus_addr), 64'hC);
    check("cons4_op",     64'(op),       64'h09080706);
    tick();
    check("cons5_rd",     64'(bus_rd),   64'h0);
    check("cons5_addr",   64'(bus_addr), 64'hE);

    // Odd jump
    pc_we = 1'b1; pc_din = 24'h001235; tick();
    check("odd_pc",       64'(pc),       64'h001235);
    check("odd_addr",     64'(bus_addr), 64'h001234);
    check("odd_rd_low",   64'(bus_rd),   64'h0);
    check("odd_op_ok",    64'(op_ok),    64'h0);
    check("odd_op_flush", 64'(op),       64'h0);
    pc_we = 1'b0; tick();
    check("odd_rd_rise",  64'(bus_rd),   64'h1);
    check("odd_first_rd", 64'(bus_addr), 64'h001234);
    tick();
    check("odd_skip_op",  64'(op),       64'h00000035);
    check("odd_addr2",    64'(bus_addr), 64'h001236);
    tick();
    check("odd_op3",      64'(op),       64'h00373635);
    check("odd_ok_early", 64'(op_ok),    64'h0);
    tick();
    check("odd_op_ok",    64'(op_ok),    64'h1);
    check("odd_op",       64'(op),       64'h38373635);

    // Flush during a wait-stated read
    mem_wait = 3; tick();
    check("ws_rd_full",   64'(bus_rd),   64'h0);
    fetched = 2'd3; tick();
    check("ws_pc",        64'(pc),       64'h001238);
    check("ws_op",        64'(op),       64'h3B3A3938);
    check("ws_rd",        64'(bus_rd),   64'h1);
    check("ws_addr",      64'(bus_addr), 64'h00123C);
    fetched = 2'd0; tick(); tick(); tick();
    pc_we = 1'b1; pc_din = 24'h000100; tick();
    check("fl_rd_low",    64'(bus_rd),   64'h0);
    check("fl_pc",        64'(pc),       64'h000100);
    check("fl_op",        64'(op),       64'h0);
    pc_we = 1'b0; tick();
    n = 1;
    check("fl_rd_rise",   64'(bus_rd),   64'h1);
    check("fl_addr",      64'(bus_addr), 64'h000100);
    while (!op_ok && n < 30) begin
      tick();
      n++;
    end
    check("fl_latency",   64'(n),        64'd9);
    check("fl_op",        64'(op),       64'h03020100);
    check("fl_pc_hold",   64'(pc),       64'h000100);

    // cen stall mid-fill
    mem_wait = 0;
    pc_we = 1'b1; pc_din = 24'h000200; tick();
    pc_we = 1'b0; tick(); tick();
    check("st_pre_pc",    64'(pc),       64'h000200);
    check("st_pre_op",    64'(op),       64'h00000100);
    check("st_pre_rd",    64'(bus_rd),   64'h1);
    for (int i = 0; i < 5; i++) begin
      cen     = 1'b0;
      toggle  = (i < 4);
      fetched = i[0] ? 2'd1 : 2'd2;
      tick();
      check("st_hold_pc", 64'(pc), 64'h000200);
      check("st_hold_outs", 64'({op, bus_addr, op_ok, bus_rd}),
            64'({32'h00000100, 24'h000202, 1'b0, 1'b1}));
    end
    toggle = 1'b0; cen = 1'b1; fetched = 2'd0; tick();
    check("st_res_ok",    64'(op_ok),    64'h1);
    check("st_res_op",    64'(op),       64'h03020100);
    check("st_res_pc",    64'(pc),       64'h000200);
    check("st_res_addr",  64'(bus_addr), 64'h000204);

    // Address wrap
    pc_we = 1'b1; pc_din = 24'hFFFFFE; tick();
    check("wr_pc",        64'(pc),       64'hFFFFFE);
    check("wr_addr0",     64'(bus_addr), 64'hFFFFFE);
    pc_we = 1'b0; tick();
    check("wr_rd",        64'(bus_rd),   64'h1);
    check("wr_addr1",     64'(bus_addr), 64'hFFFFFE);
    tick();
    check("wr_addr_wrap", 64'(bus_addr), 64'h000000);
    check("wr_op1",       64'(op),       64'h0000FFFE);
    fetched = 2'd2; tick();
    fetched = 2'd0;
    check("wr_pc_wrap",   64'(pc),       64'h000000);
    check("wr_op2",       64'(op),       64'h00000100);
    check("wr_addr2",     64'(bus_addr), 64'h000002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
